sequence_scheduler: RTL

- Shares one `sequence_generator` (8-bit data, enable-driven advance) between NUM_REQ requesters.
- Round-robin arbitration grants one requester a burst of N words.
- Drives the generator's enable and clear, and forwards each generated word downstream on a valid/ready stream tagged with requester id and last flag.
- Sits between the generator instance and its consumers.

---
 rtl/seq_sched_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/sequence_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_sched_pkg.sv
// ---------------------------------------------------------------------------
// seq_sched_pkg: shared types, defaults and helpers for sequence_scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_LEN_W   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    CLEAR  = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: combinational priority scan from a rotating start pointer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index,
  output logic               valid
);

  always_comb begin
    logic [ID_W:0] cand;
    cand  = '0;
    valid = 1'b0;
    index = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      // one extra bit holds ptr+j before wrapping back into range
      cand = {1'b0, ptr} + (ID_W+1)'(j);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!valid && req[cand[ID_W-1:0]]) begin
        valid = 1'b1;
        index = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (valid) grant = NUM_REQ'(1) << index;
  end

endmodule

`default_nettype wire

// File: rtl/sequence_scheduler.sv
// ---------------------------------------------------------------------------
// sequence_scheduler: round-robin burst sharing of one sequence_generator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sequence_scheduler
  import seq_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2(NUM_REQ),
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ-1:0]       req_restart,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     gen_enable,
  output logic                     gen_clear,
  input  logic [7:0]               gen_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last,
  output logic                     busy
);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    winner;
  logic [LEN_W-1:0]   count;
  logic [LEN_W-1:0]   lens [NUM_REQ];
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_len_unpack
      assign lens[i] = req_len[i*LEN_W +: LEN_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .index (arb_idx),
    .valid (arb_valid)
  );

  // the generator only advances when the output slot is free or freeing
  assign gen_enable = (state == RUN) && (!out_valid || out_ready);
  assign gen_clear  = !reset_n || (state == CLEAR);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      count     <= '0;
      grant     <= '0;
      done      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) state <= ARB;
        end
        ARB: begin
          if (arb_valid) begin
            winner <= arb_idx;
            count  <= lens[arb_idx];
            grant  <= arb_grant;
            ptr    <= (arb_idx == ID_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
            if (req_restart[arb_idx])      state <= CLEAR;
            else if (lens[arb_idx] != '0)  state <= RUN;
            else                           state <= FINISH;
          end else begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          state <= (count != '0) ? RUN : FINISH;
        end
        RUN: begin
          if (gen_enable) begin
            out_data  <= gen_data;
            out_valid <= 1'b1;
            out_id    <= winner;
            out_last  <= (count == LEN_W'(1));
            count     <= count - 1'b1;
            if (count == LEN_W'(1)) state <= FINISH;
          end
        end
        FINISH: begin
          if (!out_valid) begin
            done  <= grant;
            grant <= '0;
            state <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
